hilo_muldiv: RTL and testbench

Multiply/divide unit with the architectural HI/LO registers; it sits beside the ALU in the EX stage and receives the same rs/rt operands. It executes MULT/MULTU in one extra cycle and DIV/DIVU as a 32-iteration restoring divider. It executes MTHI/MTLO immediately and drives a stall request so the pipeline holds EX until results are in HI/LO. HI/LO outputs feed the MFHI/MFLO path.

---
 rtl/hilo_muldiv.sv | 154 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multiply/divide unit holding the architectural HI/LO registers.
// Executes MULT/MULTU in one extra cycle and DIV/DIVU as a fixed-latency
// 32-iteration restoring divider; MTHI/MTLO write HI/LO directly.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - EX stage holds a mul/div/mthi/mtlo instruction
//   op     - operation select (MULT/MULTU/DIV/DIVU/MTHI/MTLO, others ignored)
//   a, b   - rs / rt operands
//   cancel - pipeline flush, aborts any operation in flight
//   busy   - stall request to the hazard unit (combinational issue term)
//   done   - one-cycle pulse when new HI/LO results become visible
//   hi, lo - HI and LO registers
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} state_t;

    state_t          state;
    logic [W-1:0]    opnd_a;   // multiplicand, or dividend shifting into quotient
    logic [W-1:0]    opnd_b;   // multiplier, or divisor magnitude
    logic [W-1:0]    rem;
    logic [CW-1:0]   count;
    logic            sgn_mul;
    logic            neg_q;
    logic            neg_r;

    logic            is_mul;
    logic            is_div;
    logic            accept;
    logic            sdiv;
    logic [W-1:0]    a_abs;
    logic [W-1:0]    b_abs;
    logic [2*W-1:0]  ext_a;
    logic [2*W-1:0]  ext_b;
    logic [2*W-1:0]  product;
    logic [W:0]      rem_sh;
    logic [W-1:0]    rem_sub;
    logic            fits;

    // Issue decode and combinational stall so the hold applies in the issue cycle
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign accept = (state == IDLE) && start && !done && !cancel;
    assign busy   = (state != IDLE) || (start && (state == IDLE) && !done && (is_mul || is_div));

    // Operand magnitudes for signed divide; -2^31 maps onto itself as unsigned 2^31
    assign sdiv  = (op == OP_DIV);
    assign a_abs = (sdiv && a[W-1]) ? -a : a;
    assign b_abs = (sdiv && b[W-1]) ? -b : b;

    // Sign-extend to 64 bits so one unsigned multiply serves both MULT and MULTU
    assign ext_a   = {{W{sgn_mul & opnd_a[W-1]}}, opnd_a};
    assign ext_b   = {{W{sgn_mul & opnd_b[W-1]}}, opnd_b};
    assign product = ext_a * ext_b;

    // One restoring step; the shifted remainder needs a 33rd bit for the compare
    assign rem_sh  = {rem, opnd_a[W-1]};
    assign fits    = rem_sh >= {1'b0, opnd_b};
    assign rem_sub = rem_sh[W-1:0] - opnd_b;

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            count   <= '0;
            opnd_a  <= '0;
            opnd_b  <= '0;
            rem     <= '0;
            sgn_mul <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (cancel) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                opnd_a  <= a;
                                opnd_b  <= b;
                                sgn_mul <= (op == OP_MULT);
                                state   <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                opnd_a <= a_abs;
                                opnd_b <= b_abs;
                                neg_r  <= sdiv & a[W-1];
                                neg_q  <= sdiv & (a[W-1] ^ b[W-1]);
                                rem    <= '0;
                                count  <= CW'(31);
                                state  <= DIV;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    hi    <= product[2*W-1:W];
                    lo    <= product[W-1:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                DIV: begin
                    rem    <= fits ? rem_sub : rem_sh[W-1:0];
                    opnd_a <= {opnd_a[W-2:0], fits};
                    if (count == '0) begin
                        state <= SIGN;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                SIGN: begin
                    // With a zero divisor the remainder already equals the dividend
                    lo    <= (opnd_b == '0) ? '1 : (neg_q ? -opnd_a : opnd_a);
                    hi    <= neg_r ? -rem : rem;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed and random checks of hilo_muldiv against an
// arithmetic reference of HI/LO results, latency and stall behaviour.
module tb_hilo_muldiv;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_NONE7 = 3'b111;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors;
    int checks;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    hilo_muldiv dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural result {HI, LO} computed with plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        p  = '0;
        case (o)
            OP_MULT:  begin q = sa * sb; p = q; end
            OP_MULTU: p = {32'h0, x} * {32'h0, y};
            OP_DIV: begin
                if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
            end
            default: p = {hi_m, lo_m};
        endcase
        return p;
    endfunction

    // Issue a mul/div, optionally holding start, and check stall, latency and result
    task automatic run_muldiv(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              input bit hold, input bit poke_mtlo);
        logic [63:0] e;
        int lat;
        int n;
        e   = ref_model(o, x, y);
        lat = (o == OP_MULT || o == OP_MULTU) ? 2 : 34;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        check("busy_issue", 64'(busy), 64'(1));
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (!hold) start = 1'b0;
            if (poke_mtlo && n == 5) begin
                start = 1'b1; op = OP_MTLO; a = 32'hDEAD_BEEF;
            end
            #1;
            if (done || n >= lat + 4) break;
            check("busy_run", 64'(busy), 64'(1));
            if (poke_mtlo && n == 6) check("lo_mtlo_ignored", 64'(lo), 64'(lo_m));
        end
        check("latency", 64'(n), 64'(lat));
        check("done_pulse", 64'(done), 64'(1));
        check("busy_at_done", 64'(busy), 64'(0));
        hi_m = e[63:32];
        lo_m = e[31:0];
        check("hi_result", 64'(hi), 64'(hi_m));
        check("lo_result", 64'(lo), 64'(lo_m));
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        #1;
        check("done_clear", 64'(done), 64'(0));
        check("no_restart", 64'(busy), 64'(0));
        check("hi_hold", 64'(hi), 64'(hi_m));
        check("lo_hold", 64'(lo), 64'(lo_m));
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] x);
        @(negedge clk);
        start = 1'b1; op = o; a = x;
        #1;
        check("mt_busy_issue", 64'(busy), 64'(0));
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        #1;
        if (o == OP_MTHI) hi_m = x;
        else lo_m = x;
        check("mt_hi", 64'(hi), 64'(hi_m));
        check("mt_lo", 64'(lo), 64'(lo_m));
        check("mt_busy", 64'(busy), 64'(0));
        check("mt_done", 64'(done), 64'(0));
    endtask

    task automatic run_nop(input logic [2:0] o, input logic [31:0] x);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = x;
        #1;
        check("nop_busy", 64'(busy), 64'(0));
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        #1;
        check("nop_done", 64'(done), 64'(0));
        check("nop_busy_after", 64'(busy), 64'(0));
        check("nop_hi", 64'(hi), 64'(hi_m));
        check("nop_lo", 64'(lo), 64'(lo_m));
    endtask

    initial begin
        logic [31:0] corners [6];
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        errors = 0;
        checks = 0;
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h0000_0002;

        rst = 1'b1; start = 1'b0; op = OP_NONE; a = '0; b = '0; cancel = 1'b0;
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        rst = 1'b0;

        run_nop(OP_NONE7, 32'h5555_5555);
        run_nop(OP_NONE, 32'h3333_3333);

        run_muldiv(OP_MULT,  32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
        run_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
        run_muldiv(OP_DIV,   32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0);
        run_muldiv(OP_DIVU,  32'h7,         32'h0, 1'b0, 1'b0);
        run_muldiv(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_muldiv(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);

        // Cancel a divide part-way; HI must keep its prior value
        run_mt(OP_MTHI, 32'hAAAA_AAAA);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_busy", 64'(busy), 64'(0));
        check("cancel_done", 64'(done), 64'(0));
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            #1;
            check("cancel_no_done", 64'(done), 64'(0));
        end
        check("cancel_hi", 64'(hi), 64'(32'hAAAA_AAAA));
        check("cancel_lo", 64'(lo), 64'(lo_m));

        // Cancel blocks an MTLO issued in the same cycle
        @(negedge clk);
        start = 1'b1; op = OP_MTLO; a = 32'h0BAD_0BAD; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = OP_NONE;
        #1;
        check("cancel_mtlo", 64'(lo), 64'(lo_m));

        run_mt(OP_MTHI, 32'h1234_5678);
        run_mt(OP_MTLO, 32'h9ABC_DEF0);
        run_muldiv(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);

        // Reset in the middle of a divide returns everything to reset values
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        hi_m = '0; lo_m = '0;
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            ry = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if (ry == 32'h0) rx[31] = 1'b0;
            case (ro)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:
                    run_muldiv(ro, rx, ry, 1'($urandom_range(0, 1)), 1'b0);
                OP_MTHI, OP_MTLO: run_mt(ro, rx);
                default: run_nop(ro, rx);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
